eeprom_i2c_byte_master: RTL and testbench
=========================================

# eeprom_i2c_byte_master

Byte-level I2C master for the on-board serial EEPROM. It sits directly downstream of the 11-bit EEPROM-control PIO: it consumes the PIO output word as a command and returns an 11-bit status word to the PIO input port. Software sequences START, address, data and STOP one primitive at a time. The block drives open-drain SCL/SDA enables toward the pad ring.

## Interface
- CLK_FREQ_HZ, 50000000, frequency of clk.
- SCL_FREQ_HZ, 100000, target SCL rate.
- QDIV (localparam) = CLK_FREQ_HZ/(4*SCL_FREQ_HZ), integer division; clocks per quarter bit; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cmd_word  in  11  from PIO out_port; [10:8] cmd, [7:0] tx byte.
- status_word  out  11  to PIO in_port; [7:0] rx_data, [8] busy, [9] nack, [10] done.
- sda_i  in  1  SDA pad level, pre-synchronised.
- scl_oe  out  1  1 = pull SCL low; 0 = release.
- sda_oe  out  1  1 = pull SDA low; 0 = release.

## Operation
- Commands: 000 IDLE, 001 START, 010 WRITE, 011 READ_ACK, 100 READ_NACK, 101 STOP, 110/111 reserved.
- A one-stage register cmd_q samples cmd_word[10:8].
- Accept when busy=0 and cmd_word[10:8]!=000 and cmd_q==000 (a 000 to non-zero transition). Otherwise the field is ignored.
- On accept, tx byte and cmd are latched. Later changes to cmd_word are ignored until completion.
- On accept, done clears and busy sets.
- Quarter-tick counter runs 0..QDIV-1 while busy. Each bit is 4 quarters, q0..q3.
- FSM states: IDLE, START, XFER (bits 0..7, MSB first), ACKBIT, STOP, FINISH.
- START: q0 release SDA (SCL unchanged); q1 release SCL; q2 drive SDA low; q3 drive SCL low. Also valid as a repeated START.
- WRITE bit: q0 set sda_oe=~bit with SCL low; q1 release SCL; q2 hold; q3 drive SCL low.
- WRITE ACKBIT: SDA released; sample sda_i on the last clk of q2; nack <= sda_i. nack clears on WRITE accept.
- READ: SDA released for 8 bits; sample sda_i on the last clk of q2; shift in MSB first. rx_data updates at completion only.
- READ ACKBIT: sda_oe=1 for READ_ACK, 0 for READ_NACK.
- STOP: q0 drive SDA low (SCL low); q1 release SCL; q2 release SDA; q3 hold. Bus ends idle with both lines released.
- Completion: busy clears, done sets. done stays set until cmd_word[10:8] reads 000, then clears next clk.
- Reserved commands: accepted; done set one clk later; no bus activity; nack and rx_data unchanged.
- No clock stretching and no arbitration (single master).

## Timing
- Reset values: scl_oe=0, sda_oe=0, status_word=0, FSM IDLE, counters 0.
- Accept latency: busy=1 on the first clk edge where cmd_word is non-zero while cmd_q==000.
- busy duration: START = 4*QDIV clks, STOP = 4*QDIV, WRITE/READ = 36*QDIV. Reserved commands = 1 clk.
- busy falls and done rises on the same edge. nack/rx_data are valid on that edge.
- Outputs are registered. Bus line changes occur on the first clk of a quarter.
- Holding cmd non-zero after done does not retrigger. A new command requires cmd to return to 000 for at least 1 clk.
- Reset mid-operation releases both lines immediately (async). Software must then issue START+STOP to recover the EEPROM.
- Command returning to 000 while busy: ignored; done will still assert and then clear on the following clk.

## Test plan
- CLK_FREQ_HZ=4000000, SCL_FREQ_HZ=100000 (QDIV=10). Reset, then cmd 001 -> SDA falls while SCL high; busy high exactly 40 clks; done=1; SCL ends low.
- WRITE 0xA0 with slave model ACKing -> SDA pattern 1,0,1,0,0,0,0,0 on SCL high; 9 SCL pulses; 360 busy clks; nack=0.
- WRITE 0x55 with no slave (sda_i=1) -> nack=1, done=1. A following WRITE with ACK -> nack=0.
- READ_NACK with slave driving 0x3C -> rx_data=0x3C; sda_oe=0 during the 9th bit. READ_ACK -> sda_oe=1 during the 9th bit.
- STOP after READ -> SDA rises while SCL high; scl_oe=sda_oe=0 at end; 40 busy clks.
- Hold cmd=010 after done, change the byte while busy, then assert reset_n=0 at bit 4 -> no retrigger; the latched byte is sent; on reset, lines released and status_word=0 asynchronously.

Source files
------------

// File: rtl/eeprom_i2c_byte_master.sv
// Byte-level I2C master: executes one START/WRITE/READ/STOP primitive per PIO command
// and reports busy/done/nack/rx_data back through the status word.
module eeprom_i2c_byte_master #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned SCL_FREQ_HZ = 100000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] cmd_word,
    output logic [10:0] status_word,
    input  logic        sda_i,
    output logic        scl_oe,
    output logic        sda_oe
);
    localparam int unsigned QDIV = CLK_FREQ_HZ / (4 * SCL_FREQ_HZ);
    localparam int unsigned QW = $clog2(QDIV);
    localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);

    localparam logic [2:0] CmdIdle     = 3'b000;
    localparam logic [2:0] CmdStart    = 3'b001;
    localparam logic [2:0] CmdWrite    = 3'b010;
    localparam logic [2:0] CmdReadAck  = 3'b011;
    localparam logic [2:0] CmdReadNack = 3'b100;
    localparam logic [2:0] CmdStop     = 3'b101;

    typedef enum logic [2:0] {StIdle, StStart, StXfer, StAck, StStop, StFinish} state_e;

    state_e        st_q, st_d;
    logic [QW-1:0] qcnt_q, qcnt_d;
    logic [1:0]    quarter_q, quarter_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    cmd_q, cmd_lat_q, cmd_lat_d;
    logic [7:0]    tx_q, tx_d, shift_q, shift_d, rx_q, rx_d;
    logic          nack_q, nack_d, busy_q, busy_d, done_q, done_d;
    logic          scl_q, scl_d, sda_q, sda_d;
    logic          accept, q_end, sample, is_write, step;

    assign accept   = !busy_q && (cmd_word[10:8] != CmdIdle) && (cmd_q == CmdIdle);
    assign q_end    = (qcnt_q == QMAX);
    assign sample   = (quarter_q == 2'd2) && q_end;
    assign is_write = (cmd_lat_q == CmdWrite);

    always_comb begin
        st_d      = st_q;
        qcnt_d    = qcnt_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        cmd_lat_d = cmd_lat_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        rx_d      = rx_q;
        nack_d    = nack_q;
        busy_d    = busy_q;
        done_d    = done_q;
        scl_d     = scl_q;
        sda_d     = sda_q;
        step      = 1'b0;

        if (done_q && cmd_word[10:8] == CmdIdle) done_d = 1'b0;

        unique case (st_q)
            StIdle: begin
                if (accept) begin
                    cmd_lat_d = cmd_word[10:8];
                    tx_d      = cmd_word[7:0];
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    qcnt_d    = '0;
                    quarter_d = 2'd0;
                    bit_d     = 3'd7;
                    step      = 1'b1;
                    if (cmd_word[10:8] == CmdWrite) nack_d = 1'b0;
                    case (cmd_word[10:8])
                        CmdStart:                        st_d = StStart;
                        CmdWrite, CmdReadAck, CmdReadNack: st_d = StXfer;
                        CmdStop:                         st_d = StStop;
                        default:                         st_d = StFinish;
                    endcase
                end
            end
            StFinish: begin
                st_d   = StIdle;
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                qcnt_d = q_end ? '0 : qcnt_q + 1'b1;
                if (sample) begin
                    if (st_q == StXfer && !is_write) shift_d = {shift_q[6:0], sda_i};
                    if (st_q == StAck && is_write) nack_d = sda_i;
                end
                if (q_end) begin
                    quarter_d = quarter_q + 2'd1;
                    step      = 1'b1;
                    if (quarter_q == 2'd3) begin
                        if (st_q == StXfer) begin
                            if (bit_q == 3'd0) st_d = StAck;
                            else bit_d = bit_q - 3'd1;
                        end else begin
                            st_d   = StIdle;
                            busy_d = 1'b0;
                            done_d = 1'b1;
                            step   = 1'b0;
                            if (st_q == StAck && !is_write) rx_d = shift_q;
                        end
                    end
                end
            end
        endcase

        // Lines are updated only on entry to a quarter, from the upcoming state.
        if (step) begin
            unique case (st_d)
                StStart: begin
                    case (quarter_d)
                        2'd0:    sda_d = 1'b0;
                        2'd1:    scl_d = 1'b0;
                        2'd2:    sda_d = 1'b1;
                        default: scl_d = 1'b1;
                    endcase
                end
                StXfer, StAck: begin
                    case (quarter_d)
                        2'd0: begin
                            scl_d = 1'b1;
                            if (st_d == StAck) sda_d = (cmd_lat_d == CmdReadAck);
                            else sda_d = (cmd_lat_d == CmdWrite) ? ~tx_d[bit_d] : 1'b0;
                        end
                        2'd1:    scl_d = 1'b0;
                        2'd2:    scl_d = scl_q;
                        default: scl_d = 1'b1;
                    endcase
                end
                StStop: begin
                    case (quarter_d)
                        2'd0: begin
                            scl_d = 1'b1;
                            sda_d = 1'b1;
                        end
                        2'd1:    scl_d = 1'b0;
                        2'd2:    sda_d = 1'b0;
                        default: sda_d = sda_q;
                    endcase
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q      <= StIdle;
            qcnt_q    <= '0;
            quarter_q <= 2'd0;
            bit_q     <= 3'd0;
            cmd_q     <= CmdIdle;
            cmd_lat_q <= CmdIdle;
            tx_q      <= 8'h00;
            shift_q   <= 8'h00;
            rx_q      <= 8'h00;
            nack_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b0;
            sda_q     <= 1'b0;
        end else begin
            st_q      <= st_d;
            qcnt_q    <= qcnt_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            cmd_q     <= cmd_word[10:8];
            cmd_lat_q <= cmd_lat_d;
            tx_q      <= tx_d;
            shift_q   <= shift_d;
            rx_q      <= rx_d;
            nack_q    <= nack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
        end
    end

    assign status_word = {done_q, nack_q, busy_q, rx_q};
    assign scl_oe      = scl_q;
    assign sda_oe      = sda_q;

endmodule

// File: tb/tb_eeprom_i2c_byte_master.sv
// Directed bench for eeprom_i2c_byte_master at QDIV=10 with a timed EEPROM slave model.
module tb_eeprom_i2c_byte_master;
    logic        clk;
    logic        reset_n;
    logic [10:0] cmd_word;
    logic [10:0] status_word;
    logic        sda_i;
    logic        scl_oe;
    logic        sda_oe;
    logic        slave_pull;
    int          checks;
    int          failures;

    assign sda_i = ~sda_oe & ~slave_pull;

    eeprom_i2c_byte_master #(
        .CLK_FREQ_HZ(4000000),
        .SCL_FREQ_HZ(100000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_word   (cmd_word),
        .status_word(status_word),
        .sda_i      (sda_i),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // mode 0: no slave, 1: slave ACKs the 9th bit, 2: slave transmits sbyte.
    task automatic run_op(input logic [2:0] cmd, input logic [7:0] data, input int mode,
                          input logic [7:0] sbyte, input int chg_t, input logic [10:0] chg_word,
                          input int abort_t, output int busy_n, output int pulses,
                          output logic [8:0] bits, output logic st_seen, output logic sp_seen,
                          output logic ack_oe, output logic [1:0] pre);
        int   t;
        int   b;
        logic scl_prev, sda_prev, scl_now, sda_now;
        cmd_word = 11'h000;
        slave_pull = 1'b0;
        @(posedge clk); #1;
        cmd_word = {cmd, data};
        @(posedge clk); #1;
        busy_n = 0; pulses = 0; bits = '0; st_seen = 1'b0; sp_seen = 1'b0;
        ack_oe = 1'b0; pre = 2'b00; t = 0;
        scl_prev = ~scl_oe;
        sda_prev = sda_i;
        while (status_word[8] === 1'b1 && busy_n < 2000) begin
            busy_n++;
            if (t == chg_t) cmd_word = chg_word;
            b = t / 40;
            if (mode == 1) slave_pull = (b == 8);
            else if (mode == 2 && b < 8) slave_pull = ~sbyte[3'(7 - b)];
            else slave_pull = 1'b0;
            if (t == 8 * 40 + 25) ack_oe = sda_oe;
            if (t == abort_t) begin
                pre = {scl_oe, sda_oe};
                #2 reset_n = 1'b0;
                slave_pull = 1'b0;
                #1;
                return;
            end
            @(posedge clk); #1;
            t++;
            scl_now = ~scl_oe;
            sda_now = sda_i;
            if (scl_now && !scl_prev) begin
                bits = {bits[7:0], sda_now};
                pulses++;
            end
            if (scl_now && scl_prev && sda_prev && !sda_now) st_seen = 1'b1;
            if (scl_now && scl_prev && !sda_prev && sda_now) sp_seen = 1'b1;
            scl_prev = scl_now;
            sda_prev = sda_now;
        end
        slave_pull = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cmd_word = 11'h000;
        slave_pull = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (scl_oe !== 1'b0) begin failures++; $display("FAIL reset_scl: got %b want 0", scl_oe); end
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL reset_sda: got %b want 0", sda_oe); end
        checks++; if (status_word !== 11'h000) begin failures++; $display("FAIL reset_status: got %h want 000", status_word); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // START, with the command dropped to 000 mid-operation.
    task automatic test_start();
        int bn, pc; logic [8:0] bits; logic ss, sp, ao; logic [1:0] pre;
        run_op(3'b001, 8'h00, 0, 8'h00, 3, 11'h000, -1, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (bn !== 40) begin failures++; $display("FAIL start_busy: got %0d want 40", bn); end
        checks++; if (ss !== 1'b1) begin failures++; $display("FAIL start_cond: got %b want 1", ss); end
        checks++; if (status_word[10] !== 1'b1) begin failures++; $display("FAIL start_done: got %b want 1", status_word[10]); end
        checks++; if (scl_oe !== 1'b1) begin failures++; $display("FAIL start_scl_low: got %b want 1", scl_oe); end
        @(posedge clk); #1;
        checks++; if (status_word[10] !== 1'b0) begin failures++; $display("FAIL start_done_clear: got %b want 0", status_word[10]); end
    endtask

    task automatic test_write_ack();
        int bn, pc; logic [8:0] bits; logic ss, sp, ao; logic [1:0] pre;
        run_op(3'b010, 8'hA0, 1, 8'h00, -1, 11'h000, -1, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (bn !== 360) begin failures++; $display("FAIL wr_busy: got %0d want 360", bn); end
        checks++; if (pc !== 9) begin failures++; $display("FAIL wr_pulses: got %0d want 9", pc); end
        checks++; if (bits !== 9'b1010_0000_0) begin failures++; $display("FAIL wr_bits: got %b want 101000000", bits); end
        checks++; if (status_word[9] !== 1'b0) begin failures++; $display("FAIL wr_nack: got %b want 0", status_word[9]); end
        checks++; if (status_word[10:8] !== 3'b100) begin failures++; $display("FAIL wr_done: got %b want 100", status_word[10:8]); end
        checks++; if (ss !== 1'b0 || sp !== 1'b0) begin failures++; $display("FAIL wr_spurious: got %b%b want 00", ss, sp); end
    endtask

    task automatic test_write_nack();
        int bn, pc; logic [8:0] bits; logic ss, sp, ao; logic [1:0] pre;
        run_op(3'b010, 8'h55, 0, 8'h00, -1, 11'h000, -1, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (bits !== 9'b0101_0101_1) begin failures++; $display("FAIL wn_bits: got %b want 010101011", bits); end
        checks++; if (status_word[10:9] !== 2'b11) begin failures++; $display("FAIL wn_nack_done: got %b want 11", status_word[10:9]); end
        run_op(3'b010, 8'h12, 1, 8'h00, -1, 11'h000, -1, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (status_word[10:9] !== 2'b10) begin failures++; $display("FAIL wn_nack_clear: got %b want 10", status_word[10:9]); end
    endtask

    task automatic test_read();
        int bn, pc; logic [8:0] bits; logic ss, sp, ao; logic [1:0] pre;
        run_op(3'b100, 8'h00, 2, 8'h3C, -1, 11'h000, -1, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (status_word[7:0] !== 8'h3C) begin failures++; $display("FAIL rd_nack_data: got %h want 3c", status_word[7:0]); end
        checks++; if (ao !== 1'b0) begin failures++; $display("FAIL rd_nack_oe: got %b want 0", ao); end
        checks++; if (bn !== 360) begin failures++; $display("FAIL rd_busy: got %0d want 360", bn); end
        run_op(3'b011, 8'h00, 2, 8'hC5, -1, 11'h000, -1, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (status_word[7:0] !== 8'hC5) begin failures++; $display("FAIL rd_ack_data: got %h want c5", status_word[7:0]); end
        checks++; if (ao !== 1'b1) begin failures++; $display("FAIL rd_ack_oe: got %b want 1", ao); end
        checks++; if (status_word[9] !== 1'b0) begin failures++; $display("FAIL rd_nack_kept: got %b want 0", status_word[9]); end
    endtask

    task automatic test_stop();
        int bn, pc; logic [8:0] bits; logic ss, sp, ao; logic [1:0] pre;
        run_op(3'b101, 8'h00, 0, 8'h00, -1, 11'h000, -1, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (sp !== 1'b1) begin failures++; $display("FAIL stop_cond: got %b want 1", sp); end
        checks++; if (bn !== 40) begin failures++; $display("FAIL stop_busy: got %0d want 40", bn); end
        checks++; if ({scl_oe, sda_oe} !== 2'b00) begin failures++; $display("FAIL stop_lines: got %b want 00", {scl_oe, sda_oe}); end
    endtask

    task automatic test_reserved();
        int bn, pc; logic [8:0] bits; logic ss, sp, ao; logic [1:0] pre;
        run_op(3'b110, 8'hFF, 0, 8'h00, -1, 11'h000, -1, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (bn !== 1) begin failures++; $display("FAIL rsv_busy: got %0d want 1", bn); end
        checks++; if (status_word !== {3'b100, 8'hC5}) begin failures++; $display("FAIL rsv_status: got %h want 4c5", status_word); end
        checks++; if (pc !== 0 || {scl_oe, sda_oe} !== 2'b00) begin failures++; $display("FAIL rsv_bus: got pulses=%0d lines=%b want 0 00", pc, {scl_oe, sda_oe}); end
    endtask

    // Hold the command after done, change the byte while busy, then reset at bit 4.
    task automatic test_back_to_back();
        int bn, pc, retrig; logic [8:0] bits; logic ss, sp, ao; logic [1:0] pre;
        run_op(3'b001, 8'h00, 0, 8'h00, -1, 11'h000, -1, bn, pc, bits, ss, sp, ao, pre);
        run_op(3'b010, 8'h96, 1, 8'h00, 5, {3'b010, 8'h00}, -1, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (bits !== 9'b1001_0110_0) begin failures++; $display("FAIL hold_latched: got %b want 100101100", bits); end
        retrig = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (status_word[8] !== 1'b0) retrig++;
        end
        checks++; if (retrig !== 0) begin failures++; $display("FAIL hold_retrig: got %0d busy clks want 0", retrig); end
        checks++; if (status_word[10] !== 1'b1) begin failures++; $display("FAIL hold_done: got %b want 1", status_word[10]); end
        run_op(3'b010, 8'h50, 1, 8'h00, -1, 11'h000, 165, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (pre !== 2'b11) begin failures++; $display("FAIL abort_pre: got %b want 11", pre); end
        checks++; if ({scl_oe, sda_oe} !== 2'b00) begin failures++; $display("FAIL abort_lines: got %b want 00", {scl_oe, sda_oe}); end
        checks++; if (status_word !== 11'h000) begin failures++; $display("FAIL abort_status: got %h want 000", status_word); end
    endtask

    task automatic test_recovery();
        int bn, pc; logic [8:0] bits; logic ss, sp, ao; logic [1:0] pre;
        @(posedge clk); #1;
        reset_n = 1'b1;
        run_op(3'b001, 8'h00, 0, 8'h00, -1, 11'h000, -1, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (ss !== 1'b1) begin failures++; $display("FAIL rec_start: got %b want 1", ss); end
        run_op(3'b101, 8'h00, 0, 8'h00, -1, 11'h000, -1, bn, pc, bits, ss, sp, ao, pre);
        checks++; if (sp !== 1'b1 || {scl_oe, sda_oe} !== 2'b00) begin failures++; $display("FAIL rec_stop: got stop=%b lines=%b want 1 00", sp, {scl_oe, sda_oe}); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_start();
        test_write_ack();
        test_write_nack();
        test_read();
        test_stop();
        test_reserved();
        test_back_to_back();
        test_recovery();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
